// File: rtl/execute_sequencer.sv
// Microstep sequencer: after fetch hands over an opcode, walks its microcode
// steps through an async ROM, retires the instruction and requests the next fetch.
module execute_sequencer #(
  parameter int unsigned OPCODE_WIDTH = 8,
  parameter int unsigned MS_WIDTH     = 3,
  parameter int unsigned CW_WIDTH     = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fetch_done,
  input  logic [OPCODE_WIDTH-1:0]          opcode,
  output logic [OPCODE_WIDTH+MS_WIDTH-1:0] ucode_addr,
  input  logic [CW_WIDTH-1:0]              ucode_word,
  input  logic                             ucode_last,
  input  logic                             ucode_halt,
  output logic [CW_WIDTH-1:0]              control_word,
  output logic [MS_WIDTH-1:0]              current_microstep,
  output logic                             fetch_start,
  output logic                             instr_complete,
  output logic                             halted,
  output logic                             seq_error
);

  localparam logic [MS_WIDTH-1:0] MS_MAX = '1;

  typedef enum logic [2:0] {
    FETCH_REQ,
    WAIT_FETCH,
    EXECUTE,
    COMPLETE,
    HALTED
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic [MS_WIDTH-1:0]     microstep;
  logic                    in_exec;
  logic                    step_halt;
  logic                    step_last;
  logic                    step_wrap;

  // Resolve the ROM flags in priority order: halt, last, counter overflow.
  assign in_exec   = (state == EXECUTE);
  assign step_halt = in_exec & ucode_halt;
  assign step_last = in_exec & ~ucode_halt & ucode_last;
  assign step_wrap = in_exec & ~ucode_halt & ~ucode_last & (microstep == MS_MAX);

  assign ucode_addr        = {opcode_q, microstep};
  assign current_microstep = microstep;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH_REQ:  state_nxt = WAIT_FETCH;
      WAIT_FETCH: if (fetch_done) state_nxt = EXECUTE;
      EXECUTE: begin
        if (step_halt) begin
          state_nxt = HALTED;
        end else if (step_last || step_wrap) begin
          state_nxt = COMPLETE;
        end
      end
      COMPLETE:   state_nxt = FETCH_REQ;
      HALTED:     state_nxt = HALTED;
      default:    state_nxt = FETCH_REQ;
    endcase
  end

  // fetch_start is held off while reset is asserted even though the state already reads FETCH_REQ.
  always_comb begin
    control_word = '0;
    fetch_start  = 1'b0;
    unique case (state)
      FETCH_REQ:  fetch_start  = reset;
      EXECUTE:    control_word = ucode_word;
      WAIT_FETCH,
      COMPLETE,
      HALTED:     control_word = '0;
      default:    control_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      opcode_q       <= '0;
      microstep      <= '0;
      halted         <= 1'b0;
      seq_error      <= 1'b0;
      instr_complete <= 1'b0;
    end else begin
      instr_complete <= step_halt | step_last | step_wrap;
      if (state == WAIT_FETCH && fetch_done) begin
        opcode_q  <= opcode;
        microstep <= '0;
      end else if (step_last || step_wrap) begin
        microstep <= '0;
      end else if (in_exec && !ucode_halt) begin
        microstep <= microstep + MS_WIDTH'(1);
      end
      if (step_halt) halted <= 1'b1;
      if (step_wrap) seq_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_execute_sequencer.sv
// Bench for execute_sequencer: directed scenarios plus randomized instructions
// checked against a ROM-walking reference model.
module tb_execute_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_done;
  logic [7:0]  opcode;
  logic [10:0] ucode_addr;
  logic [31:0] ucode_word;
  logic        ucode_last;
  logic        ucode_halt;
  logic [31:0] control_word;
  logic [2:0]  current_microstep;
  logic        fetch_start;
  logic        instr_complete;
  logic        halted;
  logic        seq_error;

  logic [31:0] rom_w [2048];
  logic        rom_l [2048];
  logic        rom_h [2048];

  int checks = 0;
  int passes = 0;
  bit err_exp = 1'b0;

  always #5 clk = ~clk;

  assign ucode_word = rom_w[ucode_addr];
  assign ucode_last = rom_l[ucode_addr];
  assign ucode_halt = rom_h[ucode_addr];

  execute_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .fetch_done        (fetch_done),
    .opcode            (opcode),
    .ucode_addr        (ucode_addr),
    .ucode_word        (ucode_word),
    .ucode_last        (ucode_last),
    .ucode_halt        (ucode_halt),
    .control_word      (control_word),
    .current_microstep (current_microstep),
    .fetch_start       (fetch_start),
    .instr_complete    (instr_complete),
    .halted            (halted),
    .seq_error         (seq_error)
  );

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [10:0] idx(input logic [7:0] op, input int s);
    return {op, 3'(s)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the ROM for op; length, halt and overflow follow from the flag priority.
  task automatic plan(input logic [7:0] op, output int n, output bit h, output bit e);
    n = 8; h = 1'b0; e = 1'b1;
    for (int s = 0; s < 8; s++) begin
      if (rom_h[idx(op, s)]) begin n = s + 1; h = 1'b1; e = 1'b0; break; end
      if (rom_l[idx(op, s)]) begin n = s + 1; e = 1'b0; break; end
    end
  endtask

  task automatic clear_op(input logic [7:0] op);
    for (int s = 0; s < 8; s++) begin
      rom_w[idx(op, s)] = '0;
      rom_l[idx(op, s)] = 1'b0;
      rom_h[idx(op, s)] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    fetch_done = 1'b1;
    opcode     = 8'($urandom);
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_cw", control_word, 32'd0);
      check("rst_fetch_start", 32'(fetch_start), 32'd0);
      check("rst_instr_complete", 32'(instr_complete), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_seq_error", 32'(seq_error), 32'd0);
      check("rst_microstep", 32'(current_microstep), 32'd0);
      check("rst_addr", 32'(ucode_addr), 32'd0);
    end
    fetch_done = 1'b0;
    err_exp    = 1'b0;
    reset      = 1'b1;
    #1;
  endtask

  // Enters in a FETCH_REQ cycle; returns in the next FETCH_REQ cycle, or in the first HALTED cycle.
  task automatic do_instr(input logic [7:0] op, output int n, output bit h);
    bit e;
    int k;
    plan(op, n, h, e);
    check("fetch_start_req", 32'(fetch_start), 32'd1);
    check("req_cw", control_word, 32'd0);
    check("req_instr_complete", 32'(instr_complete), 32'd0);
    step();
    k = $urandom_range(0, 3);
    for (int c = 0; c <= k; c++) begin
      check("wait_fetch_start", 32'(fetch_start), 32'd0);
      check("wait_cw", control_word, 32'd0);
      if (c < k) step();
    end
    fetch_done = 1'b1;
    opcode     = op;
    step();
    for (int s = 0; s < n; s++) begin
      fetch_done = 1'b0;
      check("exec_microstep", 32'(current_microstep), 32'(s));
      check("exec_addr", 32'(ucode_addr), 32'(idx(op, s)));
      check("exec_cw", control_word, rom_w[idx(op, s)]);
      check("exec_fetch_start", 32'(fetch_start), 32'd0);
      check("exec_instr_complete", 32'(instr_complete), 32'd0);
      fetch_done = 1'($urandom_range(0, 1));
      opcode     = 8'($urandom);
      step();
    end
    fetch_done = 1'b0;
    err_exp    = err_exp | e;
    check("retire_instr_complete", 32'(instr_complete), 32'd1);
    check("retire_cw", control_word, 32'd0);
    check("retire_fetch_start", 32'(fetch_start), 32'd0);
    check("retire_halted", 32'(halted), 32'(h));
    check("retire_seq_error", 32'(seq_error), 32'(err_exp));
    if (!h) step();
  endtask

  task automatic halted_idle(input logic [7:0] op, input int n);
    for (int c = 0; c < 20; c++) begin
      fetch_done = 1'($urandom_range(0, 1));
      opcode     = 8'($urandom);
      step();
      check("halt_fetch_start", 32'(fetch_start), 32'd0);
      check("halt_instr_complete", 32'(instr_complete), 32'd0);
      check("halt_sticky", 32'(halted), 32'd1);
      check("halt_cw", control_word, 32'd0);
      check("halt_microstep", 32'(current_microstep), 32'(n - 1));
      check("halt_addr", 32'(ucode_addr), 32'(idx(op, n - 1)));
    end
    fetch_done = 1'b0;
  endtask

  task automatic rand_program(input logic [7:0] op, input bit allow_halt);
    int len;
    clear_op(op);
    len = $urandom_range(1, 8);
    for (int s = 0; s < 8; s++) rom_w[idx(op, s)] = $urandom;
    if (len < 8 || $urandom_range(0, 1) == 1) rom_l[idx(op, len - 1)] = 1'b1;
    if (allow_halt) begin
      rom_h[idx(op, len - 1)] = 1'b1;
      rom_l[idx(op, len - 1)] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int  n;
    bit  h;
    logic [7:0] op;
    reset      = 1'b0;
    fetch_done = 1'b0;
    opcode     = '0;
    for (int a = 0; a < 2048; a++) begin
      rom_w[a] = '0;
      rom_l[a] = 1'b0;
      rom_h[a] = 1'b0;
    end
    rom_w[idx(8'h10, 0)] = 32'h0000_00A5;
    rom_l[idx(8'h10, 0)] = 1'b1;
    rom_w[idx(8'h22, 0)] = 32'd1;
    rom_w[idx(8'h22, 1)] = 32'd2;
    rom_w[idx(8'h22, 2)] = 32'd4;
    rom_l[idx(8'h22, 2)] = 1'b1;
    rom_h[idx(8'hFF, 0)] = 1'b1;
    rom_l[idx(8'hFF, 0)] = 1'b1;
    for (int s = 0; s < 8; s++) rom_w[idx(8'h33, s)] = 32'h100 + 32'(s);

    do_reset();
    do_instr(8'h10, n, h);
    check("one_step_len", 32'(n), 32'd1);
    do_instr(8'h22, n, h);
    check("three_step_len", 32'(n), 32'd3);
    do_instr(8'h33, n, h);
    check("overflow_seq_error", 32'(seq_error), 32'd1);
    do_instr(8'h10, n, h);

    // Reset lands while MS1 of a three-step instruction is executing.
    check("mid_fetch_start", 32'(fetch_start), 32'd1);
    step();
    fetch_done = 1'b1;
    opcode     = 8'h22;
    step();
    fetch_done = 1'b0;
    check("mid_ms0_cw", control_word, 32'd1);
    step();
    check("mid_ms1", 32'(current_microstep), 32'd1);
    check("mid_ms1_cw", control_word, 32'd2);
    do_reset();
    do_instr(8'h22, n, h);

    for (int i = 0; i < 40; i++) begin
      op = 8'($urandom_range(1, 254));
      rand_program(op, 1'b0);
      do_instr(op, n, h);
    end

    do_instr(8'hFF, n, h);
    halted_idle(8'hFF, n);
    do_reset();
    check("post_halt_clear", 32'(halted), 32'd0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        op = 8'($urandom_range(1, 254));
        rand_program(op, 1'b0);
        do_instr(op, n, h);
      end
      op = 8'($urandom_range(1, 254));
      rand_program(op, 1'b1);
      do_instr(op, n, h);
      halted_idle(op, n);
      do_reset();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
